alu_issue_wb: RTL and testbench
===============================

Name: alu_issue_wb

Overview:
- Operand-issue and writeback stage wrapped around the combinational ALU of the 16-bit CPU.
- Holds the general-purpose register file and the architectural flag register.
- On each accepted instruction it reads two source registers and registers the operands, opcode, mode and carry-in into an EX register that drives the ALU.
- One cycle later it captures the ALU result and flags, and writes them back.
- Forwarding removes back-to-back data and carry hazards.

Parameters:
- DATA_WIDTH, 16, operand/result width
- REG_COUNT, 8, number of general-purpose registers
- ADDR_WIDTH, 3, register index width (log2 REG_COUNT)
- OPCODE_WIDTH, 4, ALU opcode width
- FLAG_WIDTH, 3, ALU flag vector width
- CARRY_BIT, 0, index of the carry flag within the flag vector

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- instr_valid  in  1  decoder presents an instruction
- instr_ready  out  1  stage accepts an instruction this cycle
- instr_rd  in  ADDR_WIDTH  destination register
- instr_rs1  in  ADDR_WIDTH  source A register
- instr_rs2  in  ADDR_WIDTH  source B register
- instr_opcode  in  OPCODE_WIDTH  ALU opcode
- instr_mode  in  1  0 = logic unit, 1 = arithmetic unit
- instr_use_carry  in  1  1 = carry-in from the flag register, 0 = carry-in forced to 0
- halt  in  1  control request to stop issuing
- alu_in_a  out  DATA_WIDTH  registered operand A to ALU
- alu_in_b  out  DATA_WIDTH  registered operand B to ALU
- alu_input_carry  out  1  registered carry-in to ALU
- alu_opcode  out  OPCODE_WIDTH  registered opcode to ALU
- alu_mode  out  1  registered mode to ALU
- alu_out  in  DATA_WIDTH  combinational ALU result
- alu_out_flag  in  FLAG_WIDTH  combinational ALU flags
- wb_valid  out  1  registered pulse: a writeback completed last edge
- wb_rd  out  ADDR_WIDTH  register written
- wb_data  out  DATA_WIDTH  value written
- flag_reg  out  FLAG_WIDTH  architectural flags
- dbg_addr  in  ADDR_WIDTH  debug read index
- dbg_data  out  DATA_WIDTH  combinational debug read of the register file

Behaviour:
- **Reset (rst_n low at an edge):**
  - All registers and flag_reg clear to 0.
  - EX valid clears to 0.
  - alu_in_a, alu_in_b, alu_input_carry, alu_opcode, alu_mode, wb_valid, wb_rd and wb_data clear to 0.
  - An instruction in flight is discarded and never written back.
- **Handshake:**
  - instr_ready = rst_n & ~halt.
  - An instruction is accepted when instr_valid & instr_ready at the edge.
  - Inputs may change freely while not accepted.
- **Pipeline, with acceptance at edge N:**
  - EX register loads at edge N; the ALU evaluates during cycle N..N+1.
  - At edge N+1, if EX is valid:
    - register[rd_ex] <= alu_out (skipped when rd_ex == 0);
    - flag_reg <= alu_out_flag;
    - wb_valid <= 1, wb_rd <= rd_ex, wb_data <= alu_out (reported even when rd_ex == 0).
  - If no instruction was accepted, wb_valid <= 0 and wb_rd/wb_data hold.
  - EX valid <= accepted this edge.
  - Latency from accept to register-file update: 2 edges. Throughput: 1 per cycle.
- **Register 0:** always reads 0; writes are ignored.
- **Operand select at accept, per source rs:**
  - if rs == 0, use 0;
  - else if EX valid and rs == rd_ex, use alu_out (forward);
  - else use register[rs].
- **Carry-in at accept:**
  - 0 if !instr_use_carry;
  - else alu_out_flag[CARRY_BIT] if EX valid (forward);
  - else flag_reg[CARRY_BIT].
- **Halt:**
  - No new accepts while halt is high.
  - The instruction already in EX still completes; it drains within 1 cycle.
  - alu_* outputs hold their last values.
- **Debug read:** dbg_addr == 0 returns 0; no forwarding applied.

Test Plan:
- Reset with R1 preloaded via an earlier writeback, hold rst_n low one edge -> dbg_data(R1) = 0, flag_reg = 0, wb_valid = 0.
- Accept ADD (mode 1) R3 = R1 + R2 with R1 = 0x0005 and R2 = 0x0007, ALU model attached -> alu_in_a = 0x0005 and alu_in_b = 0x0007 after edge N; wb_valid = 1, wb_rd = 3, wb_data = 0x000C after edge N+1; dbg_data(R3) = 0x000C.
- Back-to-back R3 = R1 + R2, then R4 = R3 & R1 (mode 0) in consecutive cycles -> second alu_in_a = 0x000C (forwarded); R4 = 0x0004.
- ADD 0xFFFF + 0x0001, then ADC with use_carry = 1 on the next cycle -> second alu_input_carry = 1 (forwarded from alu_out_flag); flag_reg[0] = 1 after the first writeback.
- Write to R0 with alu_out = 0x1234 -> wb_valid = 1, wb_rd = 0, wb_data = 0x1234; later read of R0 as a source yields 0.
- Assert halt the cycle after an accept, and separately drop rst_n while EX is valid -> halt: instr_ready = 0, the pending op still writes back once. Reset: no write occurs and wb_valid = 0.

Source files
------------

// File: rtl/alu_issue_wb.sv
// Operand-issue and writeback stage around the combinational ALU: register file, flag register,
// one EX register driving the ALU, and forwarding of the in-flight result and carry.
module alu_issue_wb #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned REG_COUNT    = 8,
  parameter int unsigned ADDR_WIDTH   = 3,
  parameter int unsigned OPCODE_WIDTH = 4,
  parameter int unsigned FLAG_WIDTH   = 3,
  parameter int unsigned CARRY_BIT    = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_instr_valid,
  output logic                    o_instr_ready,
  input  logic [ADDR_WIDTH-1:0]   i_instr_rd,
  input  logic [ADDR_WIDTH-1:0]   i_instr_rs1,
  input  logic [ADDR_WIDTH-1:0]   i_instr_rs2,
  input  logic [OPCODE_WIDTH-1:0] i_instr_opcode,
  input  logic                    i_instr_mode,
  input  logic                    i_instr_use_carry,
  input  logic                    i_halt,
  output logic [DATA_WIDTH-1:0]   o_alu_in_a,
  output logic [DATA_WIDTH-1:0]   o_alu_in_b,
  output logic                    o_alu_input_carry,
  output logic [OPCODE_WIDTH-1:0] o_alu_opcode,
  output logic                    o_alu_mode,
  input  logic [DATA_WIDTH-1:0]   i_alu_out,
  input  logic [FLAG_WIDTH-1:0]   i_alu_out_flag,
  output logic                    o_wb_valid,
  output logic [ADDR_WIDTH-1:0]   o_wb_rd,
  output logic [DATA_WIDTH-1:0]   o_wb_data,
  output logic [FLAG_WIDTH-1:0]   o_flag_reg,
  input  logic [ADDR_WIDTH-1:0]   i_dbg_addr,
  output logic [DATA_WIDTH-1:0]   o_dbg_data
);

  logic [DATA_WIDTH-1:0]   r_regs [REG_COUNT];
  logic [FLAG_WIDTH-1:0]   r_flag;
  logic                    r_ex_valid;
  logic [ADDR_WIDTH-1:0]   r_ex_rd;
  logic [DATA_WIDTH-1:0]   r_alu_a;
  logic [DATA_WIDTH-1:0]   r_alu_b;
  logic                    r_alu_cin;
  logic [OPCODE_WIDTH-1:0] r_alu_opcode;
  logic                    r_alu_mode;
  logic                    r_wb_valid;
  logic [ADDR_WIDTH-1:0]   r_wb_rd;
  logic [DATA_WIDTH-1:0]   r_wb_data;

  logic                    w_ready;
  logic                    w_accept;
  logic [DATA_WIDTH-1:0]   w_op_a;
  logic [DATA_WIDTH-1:0]   w_op_b;
  logic                    w_cin;

  assign w_ready  = i_rst_n & ~i_halt;
  assign w_accept = i_instr_valid & w_ready;

  // R0 wins over forwarding, so a writeback to R0 in EX never leaks into a source.
  always_comb begin
    w_op_a = '0;
    w_op_b = '0;
    w_cin  = 1'b0;
    if (i_instr_rs1 != '0) begin
      w_op_a = (r_ex_valid && (i_instr_rs1 == r_ex_rd)) ? i_alu_out : r_regs[i_instr_rs1];
    end
    if (i_instr_rs2 != '0) begin
      w_op_b = (r_ex_valid && (i_instr_rs2 == r_ex_rd)) ? i_alu_out : r_regs[i_instr_rs2];
    end
    if (i_instr_use_carry) begin
      w_cin = r_ex_valid ? i_alu_out_flag[CARRY_BIT] : r_flag[CARRY_BIT];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        r_regs[i] <= '0;
      end
      r_flag       <= '0;
      r_ex_valid   <= 1'b0;
      r_ex_rd      <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_cin    <= 1'b0;
      r_alu_opcode <= '0;
      r_alu_mode   <= 1'b0;
      r_wb_valid   <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_data    <= '0;
    end else begin
      if (r_ex_valid) begin
        if (r_ex_rd != '0) begin
          r_regs[r_ex_rd] <= i_alu_out;
        end
        r_flag     <= i_alu_out_flag;
        r_wb_valid <= 1'b1;
        r_wb_rd    <= r_ex_rd;
        r_wb_data  <= i_alu_out;
      end else begin
        r_wb_valid <= 1'b0;
      end
      r_ex_valid <= w_accept;
      if (w_accept) begin
        r_ex_rd      <= i_instr_rd;
        r_alu_a      <= w_op_a;
        r_alu_b      <= w_op_b;
        r_alu_cin    <= w_cin;
        r_alu_opcode <= i_instr_opcode;
        r_alu_mode   <= i_instr_mode;
      end
    end
  end

  assign o_instr_ready     = w_ready;
  assign o_alu_in_a        = r_alu_a;
  assign o_alu_in_b        = r_alu_b;
  assign o_alu_input_carry = r_alu_cin;
  assign o_alu_opcode      = r_alu_opcode;
  assign o_alu_mode        = r_alu_mode;
  assign o_wb_valid        = r_wb_valid;
  assign o_wb_rd           = r_wb_rd;
  assign o_wb_data         = r_wb_data;
  assign o_flag_reg        = r_flag;
  assign o_dbg_data        = (i_dbg_addr == '0) ? '0 : r_regs[i_dbg_addr];

endmodule

// File: tb/tb_alu_issue_wb.sv
// Directed bench for alu_issue_wb with a small ALU model attached; opcode F in logic mode
// passes an immediate so the bench can preload registers.
module tb_alu_issue_wb;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  instr_rd;
  logic [2:0]  instr_rs1;
  logic [2:0]  instr_rs2;
  logic [3:0]  instr_opcode;
  logic        instr_mode;
  logic        instr_use_carry;
  logic        halt;
  logic [15:0] alu_in_a;
  logic [15:0] alu_in_b;
  logic        alu_input_carry;
  logic [3:0]  alu_opcode;
  logic        alu_mode;
  logic [15:0] alu_out;
  logic [2:0]  alu_out_flag;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic [2:0]  flag_reg;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  logic [15:0] imm;
  int          n_chk;
  int          n_fail;

  alu_issue_wb dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_instr_valid     (instr_valid),
    .o_instr_ready     (instr_ready),
    .i_instr_rd        (instr_rd),
    .i_instr_rs1       (instr_rs1),
    .i_instr_rs2       (instr_rs2),
    .i_instr_opcode    (instr_opcode),
    .i_instr_mode      (instr_mode),
    .i_instr_use_carry (instr_use_carry),
    .i_halt            (halt),
    .o_alu_in_a        (alu_in_a),
    .o_alu_in_b        (alu_in_b),
    .o_alu_input_carry (alu_input_carry),
    .o_alu_opcode      (alu_opcode),
    .o_alu_mode        (alu_mode),
    .i_alu_out         (alu_out),
    .i_alu_out_flag    (alu_out_flag),
    .o_wb_valid        (wb_valid),
    .o_wb_rd           (wb_rd),
    .o_wb_data         (wb_data),
    .o_flag_reg        (flag_reg),
    .i_dbg_addr        (dbg_addr),
    .o_dbg_data        (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: flags are {neg, zero, carry}.
  logic [16:0] sum;
  always_comb begin
    sum          = 17'(alu_in_a) + 17'(alu_in_b) + 17'(alu_input_carry);
    alu_out      = 16'h0000;
    alu_out_flag = 3'b000;
    if (alu_mode) begin
      alu_out         = sum[15:0];
      alu_out_flag[0] = sum[16];
    end else if (alu_opcode == 4'hF) begin
      alu_out = imm;
    end else begin
      alu_out = alu_in_a & alu_in_b;
    end
    alu_out_flag[1] = (alu_out == 16'h0000);
    alu_out_flag[2] = alu_out[15];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic [3:0] op, input logic mode, input logic uc);
    instr_rd        = rd;
    instr_rs1       = rs1;
    instr_rs2       = rs2;
    instr_opcode    = op;
    instr_mode      = mode;
    instr_use_carry = uc;
    instr_valid     = 1'b1;
    tick();
    instr_valid     = 1'b0;
  endtask

  task automatic load(input logic [2:0] rd, input logic [15:0] val);
    imm = val;
    issue(rd, 3'd0, 3'd0, 4'hF, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    n_chk           = 0;
    n_fail          = 0;
    rst_n           = 1'b0;
    instr_valid     = 1'b0;
    instr_rd        = '0;
    instr_rs1       = '0;
    instr_rs2       = '0;
    instr_opcode    = '0;
    instr_mode      = 1'b0;
    instr_use_carry = 1'b0;
    halt            = 1'b0;
    dbg_addr        = '0;
    imm             = '0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", 32'(instr_ready), 32'd1);

    // Reset clears a preloaded register
    load(3'd1, 16'h0055);
    dbg_addr = 3'd1;
    #1;
    check("preload_r1", 32'(dbg_data), 32'h0055);
    rst_n = 1'b0;
    tick();
    check("rst_r1", 32'(dbg_data), 32'h0000);
    check("rst_flag", 32'(flag_reg), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_alu_a", 32'(alu_in_a), 32'd0);
    rst_n = 1'b1;

    // ADD R3 = R1 + R2
    load(3'd1, 16'h0005);
    load(3'd2, 16'h0007);
    issue(3'd3, 3'd1, 3'd2, 4'h0, 1'b1, 1'b0);
    check("add_a", 32'(alu_in_a), 32'h0005);
    check("add_b", 32'(alu_in_b), 32'h0007);
    check("add_mode", 32'(alu_mode), 32'd1);
    tick();
    check("add_wb_valid", 32'(wb_valid), 32'd1);
    check("add_wb_rd", 32'(wb_rd), 32'd3);
    check("add_wb_data", 32'(wb_data), 32'h000C);
    dbg_addr = 3'd3;
    #1;
    check("add_r3", 32'(dbg_data), 32'h000C);
    tick();
    check("idle_wb_valid", 32'(wb_valid), 32'd0);
    check("idle_wb_hold", 32'(wb_data), 32'h000C);

    // Back-to-back data forwarding, R3 cleared first so only forwarding can supply 0x000C
    load(3'd3, 16'h0000);
    issue(3'd3, 3'd1, 3'd2, 4'h0, 1'b1, 1'b0);
    issue(3'd4, 3'd3, 3'd1, 4'h0, 1'b0, 1'b0);
    check("fwd_a", 32'(alu_in_a), 32'h000C);
    check("fwd_b", 32'(alu_in_b), 32'h0005);
    check("fwd_wb_rd3", 32'(wb_rd), 32'd3);
    tick();
    check("and_wb_data", 32'(wb_data), 32'h0004);
    dbg_addr = 3'd4;
    #1;
    check("and_r4", 32'(dbg_data), 32'h0004);

    // Carry forwarding: 0xFFFF + 1 then ADC
    load(3'd5, 16'hFFFF);
    load(3'd6, 16'h0001);
    check("carry_flag_pre", 32'(flag_reg[0]), 32'd0);
    issue(3'd7, 3'd5, 3'd6, 4'h0, 1'b1, 1'b0);
    check("ovf_cin", 32'(alu_input_carry), 32'd0);
    issue(3'd2, 3'd0, 3'd0, 4'h1, 1'b1, 1'b1);
    check("adc_cin_fwd", 32'(alu_input_carry), 32'd1);
    check("ovf_flag_c", 32'(flag_reg[0]), 32'd1);
    check("ovf_wb_data", 32'(wb_data), 32'h0000);
    tick();
    check("adc_wb_data", 32'(wb_data), 32'h0001);
    check("adc_flag_c", 32'(flag_reg[0]), 32'd0);

    // Write to R0 reported, discarded, not forwarded
    imm = 16'h1234;
    issue(3'd0, 3'd0, 3'd0, 4'hF, 1'b0, 1'b0);
    issue(3'd3, 3'd0, 3'd1, 4'h0, 1'b1, 1'b0);
    check("r0_wb_valid", 32'(wb_valid), 32'd1);
    check("r0_wb_rd", 32'(wb_rd), 32'd0);
    check("r0_wb_data", 32'(wb_data), 32'h1234);
    check("r0_src_a", 32'(alu_in_a), 32'h0000);
    dbg_addr = 3'd0;
    #1;
    check("r0_dbg", 32'(dbg_data), 32'h0000);
    tick();
    check("r0_add_wb", 32'(wb_data), 32'h0005);

    // Halt the cycle after an accept: pending op drains, new one is not accepted
    issue(3'd4, 3'd1, 3'd2, 4'h0, 1'b1, 1'b0);
    halt            = 1'b1;
    instr_rd        = 3'd5;
    instr_rs1       = 3'd2;
    instr_rs2       = 3'd2;
    instr_valid     = 1'b1;
    #1;
    check("halt_ready", 32'(instr_ready), 32'd0);
    tick();
    check("halt_wb_valid", 32'(wb_valid), 32'd1);
    check("halt_wb_rd", 32'(wb_rd), 32'd4);
    check("halt_wb_data", 32'(wb_data), 32'h0006);
    check("halt_alu_hold", 32'(alu_in_a), 32'h0005);
    tick();
    check("halt_no_wb", 32'(wb_valid), 32'd0);
    dbg_addr = 3'd5;
    #1;
    check("halt_r5_kept", 32'(dbg_data), 32'hFFFF);
    instr_valid = 1'b0;
    halt        = 1'b0;

    // Reset while EX is valid: nothing written back
    issue(3'd6, 3'd1, 3'd1, 4'h0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_ready", 32'(instr_ready), 32'd0);
    tick();
    check("rst_ex_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_ex_wb_data", 32'(wb_data), 32'h0000);
    rst_n = 1'b1;
    tick();
    check("rst_ex_discard", 32'(wb_valid), 32'd0);
    dbg_addr = 3'd6;
    #1;
    check("rst_r6", 32'(dbg_data), 32'h0000);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
